// File: rtl/lcd_write_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_write_ctrl
//
// Timing engine for an HD44780-style character LCD. Byte-wide command/data
// writes arrive over a valid/ready handshake, are buffered, and are replayed
// onto the panel pins with setup, enable-pulse, hold and execution-wait
// intervals, so software never has to bit-bang the panel.
//
// Build option:
//   LCD_FIFO_EN  defined   -> FIFO_DEPTH-entry request FIFO (FIFO_DEPTH >= 2,
//                             power of two)
//                undefined -> single holding register, FIFO_DEPTH ignored
//
// Ports:
//   clk_i        in   1  clock
//   rst_ni       in   1  asynchronous active-low reset
//   req_valid_i  in   1  write request present
//   req_rs_i     in   1  0 = command, 1 = data
//   req_data_i   in   8  byte to write
//   req_ready_o  out  1  request can be accepted this cycle
//   busy_o       out  1  buffer non-empty or a write is in progress
//   lcd_on_o     out  1  panel power/backlight enable
//   lcd_en_o     out  1  LCD enable strobe
//   lcd_rs_o     out  1  LCD register select
//   lcd_rw_o     out  1  LCD read/write (always write)
//   lcd_data_o   out  8  LCD data bus
// -----------------------------------------------------------------------------
module lcd_write_ctrl #(
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 12,
    parameter int HOLD_CYC     = 2,
    parameter int WAIT_CYC     = 2000,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    output logic       req_ready_o,
    output logic       busy_o,
    output logic       lcd_on_o,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic [7:0] lcd_data_o
);

    // One down-counter serves every interval, so it is sized for the longest.
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_SPH = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int MAX_W   = (WAIT_CYC > CLR_WAIT_CYC) ? WAIT_CYC : CLR_WAIT_CYC;
    localparam int MAX_CYC = (MAX_SPH > MAX_W) ? MAX_SPH : MAX_W;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    // Buffer interface
    logic       push;
    logic       pop;
    logic       buf_empty;
    logic       buf_full;
    logic       head_rs;
    logic [7:0] head_data;

    assign push = req_valid_i && req_ready_o;

`ifdef LCD_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [8:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;

    // Extra MSB is the wrap bit: equal pointers mean empty, equal indices
    // with differing wrap bits mean full.
    assign buf_empty = (wr_ptr_q == rd_ptr_q);
    assign buf_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign {head_rs, head_data} = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: resetting the pointers discards the contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {req_rs_i, req_data_i};
        end
    end
`else
    logic       hold_valid_q;
    logic [8:0] hold_q;

    assign buf_empty = !hold_valid_q;
    assign buf_full  = hold_valid_q;
    assign {head_rs, head_data} = hold_q;

    // Push only happens when empty and pop only when full, so they never
    // coincide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else if (push) begin
            hold_valid_q <= 1'b1;
            hold_q       <= {req_rs_i, req_data_i};
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    logic head_is_clr;
    assign head_is_clr = !head_rs &&
                         ((head_data == 8'h01) || (head_data == 8'h02) ||
                          (head_data == 8'h03));

    // FSM and pin registers
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             long_q, long_d;
    logic             on_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            long_q  <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
            on_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        long_d  = long_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!buf_empty) begin
                    pop     = 1'b1;
                    rs_d    = head_rs;
                    data_d  = head_data;
                    long_d  = head_is_clr;
                    cnt_d   = SETUP_LOAD;
                    en_d    = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = PULSE_LOAD;
                    en_d    = 1'b1;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_LOAD;
                    en_d    = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = long_q ? CLR_LOAD : WAIT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                en_d    = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is gated by reset so it reads low while rst_ni is asserted and
    // high as soon as it is released.
    assign req_ready_o = rst_ni && !buf_full;
    assign busy_o      = (state_q != ST_IDLE) || !buf_empty;
    assign lcd_on_o    = on_q;
    assign lcd_en_o    = en_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
module tb_lcd_write_ctrl;

    localparam int SETUP = 1;
    localparam int PULSE = 3;
    localparam int HOLD  = 1;
    localparam int WAITC = 5;
    localparam int CLRW  = 20;
    localparam int DEPTH = 4;
`ifdef LCD_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif
    localparam int QMIN = (CAP < 3) ? CAP : 3;

    logic       clk_i       = 1'b0;
    logic       rst_ni      = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_rs_i    = 1'b0;
    logic [7:0] req_data_i  = 8'h00;
    logic       req_ready_o;
    logic       busy_o;
    logic       lcd_on_o;
    logic       lcd_en_o;
    logic       lcd_rs_o;
    logic       lcd_rw_o;
    logic [7:0] lcd_data_o;

    lcd_write_ctrl #(
        .SETUP_CYC   (SETUP),
        .PULSE_CYC   (PULSE),
        .HOLD_CYC    (HOLD),
        .WAIT_CYC    (WAITC),
        .CLR_WAIT_CYC(CLRW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid_i(req_valid_i),
        .req_rs_i   (req_rs_i),
        .req_data_i (req_data_i),
        .req_ready_o(req_ready_o),
        .busy_o     (busy_o),
        .lcd_on_o   (lcd_on_o),
        .lcd_en_o   (lcd_en_o),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_rw_o   (lcd_rw_o),
        .lcd_data_o (lcd_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: a schedule of edge numbers per write, derived from
    // the interval rules. t counts modelled clock edges.
    int         t      = 0;
    int         rise_t = -100;
    int         fall_t = -100;
    int         done_t = -100;
    logic [8:0] mq[$];          // entries accepted but not yet popped
    logic [8:0] sq[$];          // entries the bench still wants to send
    logic       m_rs   = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_on   = 1'b0;
    bit         rnd_gate = 1'b0;
    bit         acc_now  = 1'b0;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=0x%0h expected=0x%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit         rdy;
        bit         do_pop;
        logic [8:0] e;
        int         w;
        t++;
        rdy    = (mq.size() < CAP);
        do_pop = (t - 1 >= done_t) && (mq.size() > 0);
        e      = 9'h000;
        if (do_pop) e = mq.pop_front();
        if (req_valid_i && rdy) begin
            mq.push_back({req_rs_i, req_data_i});
            void'(sq.pop_front());
            acc_now = 1'b1;
        end
        if (do_pop) begin
            m_rs   = e[8];
            m_data = e[7:0];
            rise_t = t + SETUP;
            fall_t = rise_t + PULSE;
            w      = (!e[8] && e[7:0] >= 8'h01 && e[7:0] <= 8'h03) ? CLRW : WAITC;
            done_t = fall_t + HOLD + w;
            $display("t=%0d write rs=%0d data=0x%02h en_rise=%0d idle_at=%0d",
                     t, e[8], e[7:0], rise_t, done_t);
        end
        m_on = 1'b1;
    endtask

    task automatic check_outputs();
        chk("lcd_en",   {8'h00, lcd_en_o},    {8'h00, (t >= rise_t && t < fall_t)});
        chk("lcd_data", {1'b0, lcd_data_o},   {1'b0, m_data});
        chk("lcd_rs",   {8'h00, lcd_rs_o},    {8'h00, m_rs});
        chk("busy",     {8'h00, busy_o},      {8'h00, ((t < done_t) || (mq.size() > 0))});
        chk("ready",    {8'h00, req_ready_o}, {8'h00, (mq.size() < CAP)});
        chk("lcd_rw",   {8'h00, lcd_rw_o},    9'h000);
        chk("lcd_on",   {8'h00, lcd_on_o},    {8'h00, m_on});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_en"},    {8'h00, lcd_en_o},    9'h000);
        chk({tag, "_rs"},    {8'h00, lcd_rs_o},    9'h000);
        chk({tag, "_data"},  {1'b0, lcd_data_o},   9'h000);
        chk({tag, "_rw"},    {8'h00, lcd_rw_o},    9'h000);
        chk({tag, "_on"},    {8'h00, lcd_on_o},    9'h000);
        chk({tag, "_busy"},  {8'h00, busy_o},      9'h000);
        chk({tag, "_ready"}, {8'h00, req_ready_o}, 9'h000);
    endtask

    // Valid is held with stable payload until the model says it transferred.
    task automatic drive();
        logic [31:0] r;
        if (!(req_valid_i && !acc_now)) begin
            r = $urandom;
            if (sq.size() > 0 && (!rnd_gate || $urandom_range(0, 2) != 0)) begin
                req_valid_i = 1'b1;
                {req_rs_i, req_data_i} = sq[0];
            end else begin
                req_valid_i = 1'b0;
                req_rs_i    = r[8];
                req_data_i  = r[7:0];
            end
        end
        acc_now = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_outputs();
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sq.size() > 0 || mq.size() > 0 || t < done_t) && n < budget) begin
            step();
            n++;
        end
        checks++;
        assert (n < budget) else begin
            failures++;
            $error("FAIL drain_timeout t=%0d observed=%0d expected_below=%0d", t, n, budget);
        end
    endtask

    task automatic queue_random(input int count);
        logic [31:0] r;
        for (int i = 0; i < count; i++) begin
            r = $urandom;
            if (r[2:0] == 3'd0) sq.push_back({1'b0, 6'b0, r[9:8]});
            else                sq.push_back({r[16], r[15:8]});
        end
    endtask

    initial begin
        int n;

        // Power-on reset
        #1 rst_ni = 1'b0;
        #1 check_reset("rst");
        @(negedge clk_i);
        @(negedge clk_i);
        check_reset("rst_hold");
        rst_ni = 1'b1;
        #1;
        chk("rel_ready", {8'h00, req_ready_o}, 9'h001);
        chk("rel_on",    {8'h00, lcd_on_o},    9'h000);
        chk("rel_busy",  {8'h00, busy_o},      9'h000);
        drive();

        // Idle with random bus noise: outputs must stay static
        repeat (12) step();

        // Single data write
        sq.push_back({1'b1, 8'h41});
        drain(100);

        // Clear command (long wait) followed by data; then a normal command
        sq.push_back({1'b0, 8'h01});
        sq.push_back({1'b1, 8'h55});
        drain(200);
        sq.push_back({1'b0, 8'h38});
        sq.push_back({1'b1, 8'h66});
        drain(200);
        sq.push_back({1'b0, 8'h03});
        sq.push_back({1'b0, 8'h04});
        sq.push_back({1'b0, 8'h00});
        drain(300);

        // Six requests with valid held continuously
        rnd_gate = 1'b0;
        for (int i = 0; i < 6; i++) sq.push_back({1'b1, 8'(8'hA0 + i)});
        drain(400);

        // Random traffic
        rnd_gate = 1'b1;
        queue_random(30);
        drain(3000);

        // Reset while the enable pulse is high with entries queued
        rnd_gate = 1'b0;
        for (int i = 0; i < 4; i++) sq.push_back({1'b1, 8'(8'hC0 + i)});
        n = 0;
        while (!((t >= rise_t) && (t < fall_t) && (mq.size() >= QMIN)) && n < 50) begin
            step();
            n++;
        end
        checks++;
        assert (n < 50) else begin
            failures++;
            $error("FAIL pulse_wait_timeout t=%0d observed=%0d expected_below=50", t, n);
        end
        #2 rst_ni = 1'b0;
        #1 check_reset("mid_rst");
        req_valid_i = 1'b0;
        sq.delete();
        mq.delete();
        rise_t  = -100;
        fall_t  = -100;
        done_t  = -100;
        m_rs    = 1'b0;
        m_data  = 8'h00;
        m_on    = 1'b0;
        acc_now = 1'b0;
        @(negedge clk_i);
        check_reset("mid_rst_hold");
        rst_ni = 1'b1;
        #1;
        chk("mid_rel_ready", {8'h00, req_ready_o}, 9'h001);
        chk("mid_rel_busy",  {8'h00, busy_o},      9'h000);
        chk("mid_rel_data",  {1'b0, lcd_data_o},   9'h000);
        drive();

        // Nothing stale may be replayed; then fresh traffic
        repeat (40) step();
        rnd_gate = 1'b1;
        queue_random(15);
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
